// File: rtl/keyboard_encoder.sv
// Keypad press encoder: latches debounced key strobes, serialises them lowest-index
// first into a small FIFO. Optional sticky lost-press flag under KBD_OVF_FLAG_EN.
module keyboard_encoder #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              key_pulse,
    output logic [3:0]               key_code,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [$clog2(DEPTH):0]   key_count,
    output logic                     key_ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   pending_q, pending_d;
    logic [15:0]   grant;
    logic [3:0]    grant_idx;
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, push_ok, lost;

    assign key_valid = (count_q != '0);
    assign key_count = count_q;
    // Storage is not reset, so mask the head while empty to read 0 after reset.
    assign key_code  = key_valid ? mem_q[rd_ptr_q] : 4'd0;

    always_comb begin
        pop       = key_valid & key_ready;
        push_ok   = (count_q < CW'(DEPTH)) | pop;
        grant     = push_ok ? (pending_q & (~pending_q + 16'd1)) : 16'd0;
        push      = |grant;
        grant_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (grant[i]) grant_idx = 4'(i);
        end
        pending_d = (pending_q & ~grant) | key_pulse;
        // A strobe on an already-pending, ungranted key merges into one entry.
        lost      = |(key_pulse & pending_q & ~grant);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= grant_idx;
    end

`ifdef KBD_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (lost)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign key_ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ lost;
    assign key_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_keyboard_encoder.sv
// Bench for keyboard_encoder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_keyboard_encoder;

    localparam int DEPTH = 8;
`ifdef KBD_OVF_FLAG_EN
    localparam int OVF = 1;
`else
    localparam int OVF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_pulse = '0;
    logic        key_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  key_count;
    logic        key_ovf;

    int checks = 0;
    int errors = 0;

    keyboard_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_count(key_count),
        .key_ovf(key_ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: a queue of codes and a set of pending keys.
    int       m_q[$];
    bit [15:0] m_pend;
    bit       m_ovf;
    bit       armed = 1'b0;

    always @(negedge clk) begin
        int  g;
        bit  pop, ok, found;
        if (armed) begin
            chk("mdl_valid", int'(key_valid), int'(m_q.size() > 0));
            chk("mdl_count", int'(key_count), m_q.size());
            chk("mdl_ovf",   int'(key_ovf),   int'(m_ovf));
            if (m_q.size() > 0) chk("mdl_code", int'(key_code), m_q[0]);
        end
        if (rst) begin
            m_q.delete();
            m_pend = '0;
            m_ovf  = 1'b0;
            armed  = 1'b1;
        end else begin
            pop   = (m_q.size() > 0) && key_ready;
            ok    = (m_q.size() < DEPTH) || pop;
            g     = -1;
            found = 1'b0;
            if (ok) begin
                for (int i = 0; i < 16; i++) begin
                    if (!found && m_pend[i]) begin
                        g = i;
                        found = 1'b1;
                    end
                end
            end
`ifdef KBD_OVF_FLAG_EN
            begin
                bit lostb;
                lostb = 1'b0;
                for (int i = 0; i < 16; i++)
                    if (key_pulse[i] && m_pend[i] && i != g) lostb = 1'b1;
                if (lostb)        m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
            end
`endif
            if (pop) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(g);
                m_pend[g] = 1'b0;
            end
            m_pend = m_pend | key_pulse;
        end
    end

    initial begin
        int burst_exp[3];
        int fk[10];
        burst_exp = '{0, 8, 15};
        fk = '{9, 2, 7, 4, 12, 0, 11, 6, 3, 14};

        // Reset state
        step(2);
        chk("rst_count", int'(key_count), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_code",  int'(key_code),  0);
        chk("rst_ovf",   int'(key_ovf),   0);
        rst = 1'b0;
        step(2);

        // Single press, two-cycle latency, popped immediately
        key_ready = 1'b1;
        key_pulse = 16'h0020;
        step(1);
        key_pulse = '0;
        chk("single_n1_valid", int'(key_valid), 0);
        step(1);
        chk("single_n2_valid", int'(key_valid), 1);
        chk("single_n2_code",  int'(key_code),  5);
        step(1);
        chk("single_n3_valid", int'(key_valid), 0);
        chk("single_n3_count", int'(key_count), 0);
        key_ready = 1'b0;

        // Burst of three keys in one cycle
        key_pulse = 16'h8101;
        step(1);
        key_pulse = '0;
        step(4);
        chk("burst_count", int'(key_count), 3);
        key_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("burst_code", int'(key_code), burst_exp[k]);
            step(1);
        end
        key_ready = 1'b0;
        chk("burst_empty", int'(key_count), 0);

        // Ten distinct presses into an 8-deep FIFO, then drain
        for (int k = 0; k < 10; k++) begin
            key_pulse = '0;
            key_pulse[fk[k]] = 1'b1;
            step(1);
        end
        key_pulse = '0;
        step(3);
        chk("full_count", int'(key_count), 8);
        chk("full_head",  int'(key_code),  9);
        step(3);
        chk("full_hold", int'(key_count), 8);
        key_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("full_order", int'(key_code), fk[k]);
            step(1);
            if (k < 2) chk("full_pushpop_count", int'(key_count), 8);
        end
        key_ready = 1'b0;
        chk("full_drained", int'(key_count), 0);

        // Lost press while key 3 is held pending behind a full FIFO
        key_pulse = 16'h00FF;
        step(1);
        key_pulse = '0;
        step(9);
        chk("ovf_fill", int'(key_count), 8);
        key_pulse = 16'h0008;
        step(1);
        key_pulse = 16'h0008;
        step(1);
        key_pulse = '0;
        chk("ovf_set", int'(key_ovf), OVF);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(key_ovf), 0);
        key_pulse = 16'h0008;
        ovf_clr = 1'b1;
        step(1);
        key_pulse = '0;
        ovf_clr = 1'b0;
        chk("ovf_set_wins", int'(key_ovf), OVF);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_clr2", int'(key_ovf), 0);
        chk("ovf_count", int'(key_count), 8);
        key_ready = 1'b1;
        step(10);
        key_ready = 1'b0;
        chk("ovf_drained", int'(key_count), 0);

        // Reset mid-operation with queued and pending presses
        key_pulse = 16'h001F;
        step(1);
        key_pulse = '0;
        step(5);
        chk("mid_count5", int'(key_count), 5);
        key_pulse = 16'h00F0;
        step(1);
        key_pulse = '0;
        rst = 1'b1;
        key_ready = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_count", int'(key_count), 0);
        chk("mid_rst_valid", int'(key_valid), 0);
        step(8);
        chk("mid_rst_quiet", int'(key_valid), 0);
        key_ready = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
